sdram_init_monitor: RTL and testbench

Receiving-end checker for the SDRAM power-up initialization command stream. Sits on the command/address bus between the initialization sequencer and the SDRAM pins, decodes every command, enforces order and minimum spacing of the JEDEC init sequence, and captures the programmed mode register. Downstream read/write logic gates on `sdram_ready`. `init_err` and `err_code` are sticky and drive a debug LED and signal-tap.

---
 rtl/sdram_cmd_pkg.sv | 59 +++++
 rtl/sdram_gap_timer.sv | 31 +++
 rtl/sdram_init_monitor.sv | 148 ++++++++++++++
 tb/tb_sdram_init_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command encodings, error causes and init-monitor FSM states.
// Optional mode-word validation helper, used when INIT_MON_MODE_CHECK_EN is defined.
package sdram_cmd_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CODE_NOP = 4'b0111;
  localparam logic [3:0] CODE_PRE = 4'b0010;
  localparam logic [3:0] CODE_AR  = 4'b0001;
  localparam logic [3:0] CODE_MRS = 4'b0000;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_AR,
    CMD_MRS,
    CMD_OTHER
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_EARLY_CMD = 3'd1,
    ERR_BAD_SEQ   = 3'd2,
    ERR_NO_PALL   = 3'd3,
    ERR_TIMING    = 3'd4,
    ERR_BAD_MODE  = 3'd5
  } err_t;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_WAIT_PRE,
    S_WAIT_AR,
    S_WAIT_MRS,
    S_MRD,
    S_READY,
    S_ERROR
  } state_t;

  // A deselected chip (cs_n=1) is a NOP whatever the other strobes say.
  function automatic cmd_t decode_cmd(input logic [3:0] code);
    cmd_t d;
    d = CMD_OTHER;
    if (code[3] || code == CODE_NOP) d = CMD_NOP;
    else if (code == CODE_PRE)       d = CMD_PRE;
    else if (code == CODE_AR)        d = CMD_AR;
    else if (code == CODE_MRS)       d = CMD_MRS;
    return d;
  endfunction

  // Legal mode word: reserved bits clear, CL 2 or 3, BL 1/2/4/8 or full page
  // (full page only with sequential burst type).
  function automatic logic mode_word_ok(input logic [11:0] a);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
    bl_ok = (a[2] == 1'b0) || (a[2:0] == 3'b111 && !a[3]);
    return (a[11:10] == 2'b00) && (a[8:7] == 2'b00) && cl_ok && bl_ok;
  endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Saturating cycles-since-last-command counter; min_ok says the command now on
// the bus respects the minimum spacing required by the previous command.
module sdram_gap_timer (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_strobe,
  input  logic [3:0] cmd_min,
  output logic       min_ok
);

  logic [3:0] cnt;
  logic [3:0] req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= '0;
      req <= '0;
    end else if (cmd_strobe) begin
      cnt <= '0;
      req <= cmd_min;
    end else if (cnt != 4'hF) begin
      cnt <= cnt + 4'd1;
    end
  end

  // cnt is cleared at the command edge, so the gap seen at this edge is cnt+1.
  assign min_ok = ({1'b0, cnt} + 5'd1) >= {1'b0, req};

endmodule

// File: rtl/sdram_init_monitor.sv
// Checks the SDRAM power-up init command stream and captures the mode register.
// Define INIT_MON_MODE_CHECK_EN to validate MRS words (bad word -> BAD_MODE).
module sdram_init_monitor
  import sdram_cmd_pkg::*;
#(
  parameter int T_POWERUP = 10000,
  parameter int T_RP      = 1,
  parameter int T_RFC     = 4,
  parameter int T_MRD     = 2,
  parameter int N_REFRESH = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  cmd_in,
  input  logic [11:0] addr_in,
  output logic        sdram_ready,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [11:0] mode_reg,
  output logic [1:0]  refresh_seen
);

  localparam int PWR_W = (T_POWERUP > 1) ? $clog2(T_POWERUP) : 1;
  localparam int MRD_W = (T_MRD > 1) ? $clog2(T_MRD) : 1;

  state_t           state;
  err_t             err_q;
  err_t             viol;
  logic [PWR_W-1:0] pwr_cnt;
  logic [MRD_W-1:0] mrd_cnt;
  cmd_t             cmd;
  logic             is_nop;
  logic             pall;
  logic             mode_ok;
  logic             gap_ok;
  logic [3:0]       cmd_min;
  logic [1:0]       ref_inc;

  assign cmd     = decode_cmd(cmd_in);
  assign is_nop  = (cmd == CMD_NOP);
  assign pall    = addr_in[10];
  assign ref_inc = (refresh_seen == 2'd3) ? 2'd3 : refresh_seen + 2'd1;

`ifdef INIT_MON_MODE_CHECK_EN
  assign mode_ok = mode_word_ok(addr_in);
`else
  assign mode_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cmd_min = 4'd0;
    case (cmd)
      CMD_PRE: cmd_min = 4'(T_RP);
      CMD_AR:  cmd_min = 4'(T_RFC);
      CMD_MRS: cmd_min = 4'(T_MRD);
      default: cmd_min = 4'd0;
    endcase
  end

  sdram_gap_timer u_gap_timer (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_strobe (!is_nop),
    .cmd_min    (cmd_min),
    .min_ok     (gap_ok)
  );

  always_comb begin
    viol = ERR_NONE;
    case (state)
      S_POWERUP:  if (!is_nop) viol = ERR_EARLY_CMD;
      S_WAIT_PRE: begin
        if (cmd == CMD_PRE && !pall)            viol = ERR_NO_PALL;
        else if (!is_nop && cmd != CMD_PRE)     viol = ERR_BAD_SEQ;
      end
      S_WAIT_AR: begin
        if (cmd == CMD_PRE && !pall)            viol = ERR_NO_PALL;
        else if (cmd == CMD_MRS || cmd == CMD_OTHER) viol = ERR_BAD_SEQ;
      end
      S_WAIT_MRS: begin
        if (cmd == CMD_OTHER || cmd == CMD_PRE) viol = ERR_BAD_SEQ;
        else if (cmd == CMD_MRS && !mode_ok)    viol = ERR_BAD_MODE;
      end
      S_MRD:      if (!is_nop) viol = ERR_TIMING;
      S_READY:    if (cmd == CMD_MRS && !mode_ok) viol = ERR_BAD_MODE;
      default:    viol = ERR_NONE;
    endcase
    // Spacing violations outrank any sequence error raised on the same command.
    if (state != S_POWERUP && state != S_ERROR && !is_nop && !gap_ok)
      viol = ERR_TIMING;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state        <= S_POWERUP;
      pwr_cnt      <= '0;
      mrd_cnt      <= '0;
      sdram_ready  <= 1'b0;
      init_err     <= 1'b0;
      err_q        <= ERR_NONE;
      mode_reg     <= '0;
      refresh_seen <= '0;
    end else if (viol != ERR_NONE) begin
      state       <= S_ERROR;
      sdram_ready <= 1'b0;
      init_err    <= 1'b1;
      err_q       <= viol;
    end else begin
      case (state)
        S_POWERUP: begin
          if (pwr_cnt == PWR_W'(T_POWERUP - 1)) state <= S_WAIT_PRE;
          else pwr_cnt <= pwr_cnt + PWR_W'(1);
        end
        S_WAIT_PRE: if (cmd == CMD_PRE) state <= S_WAIT_AR;
        S_WAIT_AR: begin
          if (cmd == CMD_AR) begin
            refresh_seen <= ref_inc;
            if (int'(refresh_seen) + 1 >= N_REFRESH) state <= S_WAIT_MRS;
          end
        end
        S_WAIT_MRS: begin
          if (cmd == CMD_AR) begin
            refresh_seen <= ref_inc;
          end else if (cmd == CMD_MRS) begin
            mode_reg <= addr_in;
            mrd_cnt  <= '0;
            state    <= S_MRD;
          end
        end
        S_MRD: begin
          if (mrd_cnt == MRD_W'(T_MRD - 1)) begin
            state       <= S_READY;
            sdram_ready <= 1'b1;
          end else begin
            mrd_cnt <= mrd_cnt + MRD_W'(1);
          end
        end
        S_READY: if (cmd == CMD_MRS) mode_reg <= addr_in;
        default: ;
      endcase
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Table-driven bench for sdram_init_monitor; expected outputs flow through a
// scoreboard queue. Build with INIT_MON_MODE_CHECK_EN to exercise mode checking.
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [3:0]  cmd_in  = NOP;
  logic [11:0] addr_in = '0;
  logic        sdram_ready;
  logic        init_err;
  logic [2:0]  err_code;
  logic [11:0] mode_reg;
  logic [1:0]  refresh_seen;

  sdram_init_monitor dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cmd_in       (cmd_in),
    .addr_in      (addr_in),
    .sdram_ready  (sdram_ready),
    .init_err     (init_err),
    .err_code     (err_code),
    .mode_reg     (mode_reg),
    .refresh_seen (refresh_seen)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    bit          rst;
    int          nops;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        ready;
    logic        err;
    logic [2:0]  code;
    logic [11:0] mode;
    logic [1:0]  refs;
    string       tag;
  } vec_t;

  typedef struct {
    logic        ready;
    logic        err;
    logic [2:0]  code;
    logic [11:0] mode;
    logic [1:0]  refs;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check({e.tag, ".ready"}, {11'd0, sdram_ready}, {11'd0, e.ready});
    check({e.tag, ".init_err"}, {11'd0, init_err}, {11'd0, e.err});
    check({e.tag, ".err_code"}, {9'd0, err_code}, {9'd0, e.code});
    check({e.tag, ".mode_reg"}, mode_reg, e.mode);
    check({e.tag, ".refresh_seen"}, {10'd0, refresh_seen}, {10'd0, e.refs});
  endtask

  function automatic vec_t mk(bit rst, int nops, logic [3:0] cmd, logic [11:0] addr,
                              logic rdy, logic err, logic [2:0] code,
                              logic [11:0] mode, logic [1:0] refs, string tag);
    vec_t v;
    v.rst = rst; v.nops = nops; v.cmd = cmd; v.addr = addr;
    v.ready = rdy; v.err = err; v.code = code; v.mode = mode; v.refs = refs;
    v.tag = tag;
    return v;
  endfunction

  // Reset is asserted mid-cycle, outputs checked while it is held, and released
  // just after a rising edge so the next falling edge drives the edge-1 input.
  task automatic pulse_reset(input string tag);
    exp_t z;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cmd_in  = NOP;
    addr_in = '0;
    #3;
    z.ready = 1'b0; z.err = 1'b0; z.code = 3'd0; z.mode = '0; z.refs = 2'd0;
    z.tag = {tag, ".reset"};
    check_outputs(z);
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    if (v.rst) pulse_reset(v.tag);
    for (int i = 0; i < v.nops; i++) begin
      @(negedge sys_clk);
      cmd_in  = NOP;
      addr_in = '0;
    end
    @(negedge sys_clk);
    cmd_in  = v.cmd;
    addr_in = v.addr;
    e.ready = v.ready; e.err = v.err; e.code = v.code; e.mode = v.mode;
    e.refs = v.refs; e.tag = v.tag;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", v.tag);
    end else begin
      check_outputs(sb.pop_front());
    end
  endtask

  initial begin
    // Legal bring-up interrupted by reset in WAIT_AR, then a complete legal run.
    vecs.push_back(mk(1, 10000, PRE, 12'h400, 0, 0, 3'd0, 12'h000, 2'd0, "abort_pre"));
    vecs.push_back(mk(0, 0,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd1, "abort_ar1"));
    vecs.push_back(mk(1, 10000, PRE, 12'h400, 0, 0, 3'd0, 12'h000, 2'd0, "legal_pre"));
    vecs.push_back(mk(0, 0,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd1, "legal_ar1"));
    vecs.push_back(mk(0, 3,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd2, "legal_ar2"));
    vecs.push_back(mk(0, 3,     MRS, 12'h032, 0, 0, 3'd0, 12'h032, 2'd2, "legal_mrs"));
    vecs.push_back(mk(0, 0,     NOP, 12'h000, 0, 0, 3'd0, 12'h032, 2'd2, "legal_mrd1"));
    vecs.push_back(mk(0, 0,     NOP, 12'h000, 1, 0, 3'd0, 12'h032, 2'd2, "legal_ready"));
    vecs.push_back(mk(0, 0,     MRS, 12'h031, 1, 0, 3'd0, 12'h031, 2'd2, "ready_mrs"));
    vecs.push_back(mk(0, 4,     AR,  12'h000, 1, 0, 3'd0, 12'h031, 2'd2, "ready_ar"));
    // Early command in the middle of the power-up wait; later commands keep code 1.
    vecs.push_back(mk(1, 4999,  PRE, 12'h400, 0, 1, 3'd1, 12'h000, 2'd0, "early_pre"));
    vecs.push_back(mk(0, 0,     PRE, 12'h000, 0, 1, 3'd1, 12'h000, 2'd0, "early_sticky"));
    vecs.push_back(mk(0, 12,    ACT, 12'h000, 0, 1, 3'd1, 12'h000, 2'd0, "early_noready"));
    // Command on the last edge of the power-up wait is still early.
    vecs.push_back(mk(1, 9999,  PRE, 12'h400, 0, 1, 3'd1, 12'h000, 2'd0, "edge_pre"));
    // Second refresh only two cycles after the first.
    vecs.push_back(mk(1, 10000, PRE, 12'h400, 0, 0, 3'd0, 12'h000, 2'd0, "trfc_pre"));
    vecs.push_back(mk(0, 0,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd1, "trfc_ar1"));
    vecs.push_back(mk(0, 1,     AR,  12'h000, 0, 1, 3'd4, 12'h000, 2'd1, "trfc_ar2"));
    vecs.push_back(mk(0, 5,     MRS, 12'h032, 0, 1, 3'd4, 12'h000, 2'd1, "trfc_sticky"));
    // Single-bank precharge where all-bank is required.
    vecs.push_back(mk(1, 10000, PRE, 12'h000, 0, 1, 3'd3, 12'h000, 2'd0, "nopall_pre"));
    // Mode word with CAS latency 7.
    vecs.push_back(mk(1, 10000, PRE, 12'h400, 0, 0, 3'd0, 12'h000, 2'd0, "mode_pre"));
    vecs.push_back(mk(0, 0,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd1, "mode_ar1"));
    vecs.push_back(mk(0, 3,     AR,  12'h000, 0, 0, 3'd0, 12'h000, 2'd2, "mode_ar2"));
`ifdef INIT_MON_MODE_CHECK_EN
    vecs.push_back(mk(0, 3,     MRS, 12'h072, 0, 1, 3'd5, 12'h000, 2'd2, "mode_bad"));
    vecs.push_back(mk(0, 2,     NOP, 12'h000, 0, 1, 3'd5, 12'h000, 2'd2, "mode_noready"));
`else
    vecs.push_back(mk(0, 3,     MRS, 12'h072, 0, 0, 3'd0, 12'h072, 2'd2, "mode_any"));
    vecs.push_back(mk(0, 1,     NOP, 12'h000, 1, 0, 3'd0, 12'h072, 2'd2, "mode_ready"));
`endif

    foreach (vecs[i]) apply(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
